config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 32, SHALL set the total configuration bits in the target scan chain; 4 muxes x 2 select bits x 4 sides of one switch_block gives 32.
REQ-002 Parameter WORD_W, default 8, SHALL set the width of each host data word.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a configuration load.
REQ-006 abort  input  1  SHALL cancel any load in progress.
REQ-007 data_in  input  WORD_W  SHALL carry a configuration word; bit 0 is shifted first.
REQ-008 data_valid  input  1  SHALL mean data_in is valid.
REQ-009 data_ready  output  1  SHALL mean the loader accepts data_in in this cycle.
REQ-010 scan_out  output  1  SHALL be the serial bit driven into the fabric scan_in.
REQ-011 scan_en  output  1  SHALL be the fabric shift enable.
REQ-012 busy  output  1  SHALL be high while the state is LOAD or SHIFT.
REQ-013 done  output  1  SHALL be high when exactly CHAIN_LEN bits have been shifted.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-015 All outputs SHALL be registered, or decoded directly from registered state only.
REQ-016 In IDLE or DONE, start=1 SHALL do three things: go to LOAD, set bits_left=CHAIN_LEN and clear done.
REQ-017 start while busy SHALL be ignored.
REQ-018 data_ready SHALL be 1 only in LOAD.
REQ-019 A word SHALL be accepted only on a cycle with data_valid & data_ready.
REQ-020 On acceptance, data_in SHALL load the shift register, and the FSM SHALL go to SHIFT with word_left = min(WORD_W, bits_left).
REQ-021 LOAD with data_valid=0 SHALL hold state, with scan_en=0.
REQ-022 In SHIFT, each cycle SHALL do all of the following: scan_en=1; scan_out = shift register bit 0; shift the register right by one; decrement word_left and bits_left.
REQ-023 The first bit SHALL appear on scan_out, with scan_en=1, in the cycle after acceptance.
REQ-024 Outside SHIFT, scan_en SHALL be 0 and scan_out SHALL be 0.
REQ-025 When the SHIFT cycle shifts the last bit of the word (word_left==1) and bits_left becomes 0, the FSM SHALL go to DONE; otherwise, at the end of the word, it SHALL go to LOAD.
REQ-026 Each full word SHALL cost WORD_W+1 cycles: 1 load cycle plus WORD_W shift cycles.
REQ-027 Partial last word: only the bits_left low-order bits SHALL be shifted; the upper bits SHALL be discarded.
REQ-028 DONE SHALL hold done=1 and data_ready=0 until the next start or reset.
REQ-029 The bits_left counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never underflow.
REQ-030 The word_left counter SHALL be $clog2(WORD_W+1) bits wide.
REQ-031 abort=1 in any state SHALL return the FSM to IDLE on the next edge and clear the counters; done SHALL be 0 and scan_en SHALL be 0 from that edge on.
REQ-032 abort and start in the same cycle: abort SHALL win.
REQ-033 When the FSM is in SHIFT, data_valid SHALL be ignored; no word is accepted.

Reset
REQ-034 While rst_n=0, the block SHALL immediately hold state=IDLE, counters and shift register at 0, and all outputs at 0, without waiting for clk.
REQ-035 Deassertion of rst_n SHALL be synchronised so that the first state update occurs on a clk edge; the FSM then remains in IDLE until start.
REQ-036 Reset mid-SHIFT SHALL drop scan_en within the same cycle; the partially shifted chain contents are undefined and SHALL require a fresh load.

Verification
REQ-037 Default parameters: start, then words 0xA5, 0x3C, 0xFF, 0x01 with data_valid held high -> scan_out LSB-first sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, ... ; scan_en high for exactly 32 cycles; done=1 on cycle 36 after start.
REQ-038 CHAIN_LEN=10, WORD_W=8: words 0xFF, 0xFF -> exactly 10 scan_en cycles; the second word contributes 2 bits; done=1; data_ready=0 afterward.
REQ-039 Gap stimulus: data_valid=0 for 5 cycles between words -> the FSM stays in LOAD, scan_en=0 during the gap, bit order unchanged, done after 32 shifted bits.
REQ-040 abort asserted on the 3rd SHIFT cycle of word 2 -> next cycle state=IDLE, scan_en=0, busy=0, done=0; a subsequent start reloads from bits_left=32.
REQ-041 start pulsed while busy, and start+abort in the same cycle -> the first is ignored (counter unchanged); the second ends in IDLE.
REQ-042 rst_n=0 asserted asynchronously mid-SHIFT (between clk edges) -> scan_en, busy and done fall to 0 before the next clk edge; after release, the block stays in IDLE until start.

Source files
------------

// File: rtl/config_loader.sv
// Serial configuration loader: takes host words and shifts them LSB-first
// into a fabric scan chain of CHAIN_LEN bits, one word per LOAD/SHIFT round.
module config_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              scan_out,
    output logic              scan_en,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [BW-1:0]     bits_left, bits_left_n;
    logic [WW-1:0]     word_left, word_left_n;
    logic [WORD_W-1:0] shift_reg, shift_reg_n;
    logic [1:0]        rst_sync;
    logic              rst_core_n;

    // Reset asserts immediately but releases only on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state     <= IDLE;
            bits_left <= '0;
            word_left <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            bits_left <= bits_left_n;
            word_left <= word_left_n;
            shift_reg <= shift_reg_n;
        end
    end

    always_comb begin
        state_n     = state;
        bits_left_n = bits_left;
        word_left_n = word_left;
        shift_reg_n = shift_reg;
        if (abort) begin
            state_n     = IDLE;
            bits_left_n = '0;
            word_left_n = '0;
            shift_reg_n = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n     = LOAD;
                        bits_left_n = BW'(CHAIN_LEN);
                        word_left_n = '0;
                    end
                end
                LOAD: begin
                    if (data_valid) begin
                        state_n     = SHIFT;
                        shift_reg_n = data_in;
                        // A short final word only shifts what the chain still needs.
                        if (int'(bits_left) < WORD_W) begin
                            word_left_n = WW'(bits_left);
                        end else begin
                            word_left_n = WW'(WORD_W);
                        end
                    end
                end
                SHIFT: begin
                    shift_reg_n = shift_reg >> 1;
                    word_left_n = (word_left != '0) ? word_left - WW'(1) : '0;
                    bits_left_n = (bits_left != '0) ? bits_left - BW'(1) : '0;
                    if (bits_left <= BW'(1)) begin
                        state_n = DONE;
                    end else if (word_left <= WW'(1)) begin
                        state_n = LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign scan_en    = (state == SHIFT);
    assign scan_out   = (state == SHIFT) & shift_reg[0];
    assign data_ready = (state == LOAD);
    assign busy       = (state == LOAD) | (state == SHIFT);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader: a full-chain and a short-chain instance are
// driven in turn and their scan streams compared with the expected bit sequence.
module tb_config_loader;

    localparam int W    = 8;
    localparam int CL_A = 32;
    localparam int CL_B = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         sel;

    logic a_ready, a_sout, a_sen, a_busy, a_done;
    logic b_ready, b_sout, b_sen, b_busy, b_done;
    logic data_ready, scan_out, scan_en, busy, done;
    logic start_a, start_b;

    int total = 0;
    int bad   = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    config_loader #(.CHAIN_LEN(CL_A), .WORD_W(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(a_ready),
        .scan_out(a_sout), .scan_en(a_sen), .busy(a_busy), .done(a_done)
    );

    config_loader #(.CHAIN_LEN(CL_B), .WORD_W(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(b_ready),
        .scan_out(b_sout), .scan_en(b_sen), .busy(b_busy), .done(b_done)
    );

    assign data_ready = sel ? b_ready : a_ready;
    assign scan_out   = sel ? b_sout  : a_sout;
    assign scan_en    = sel ? b_sen   : a_sen;
    assign busy       = sel ? b_busy  : a_busy;
    assign done       = sel ? b_done  : a_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fixedWord(input int i);
        case (i)
            0:       return 8'hA5;
            1:       return 8'h3C;
            2:       return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    // One complete load on the selected instance; the model is the word list
    // flattened LSB-first and cut to the chain length.
    task automatic applyStimulus(input bit use_fixed, input int gap_pct, input int junk_pct,
                                 input bit do_abort);
        int           cl, n_words, gaps, en_count, word_idx, shift_in_word, done_edge;
        bit           finished, aborted;
        logic [W-1:0] words[$];
        bit           exp_bits[$];
        bit           got_bits[$];
        logic [W-1:0] w;
        cl = sel ? CL_B : CL_A;
        n_words = (cl + W - 1) / W;
        gaps = 0; en_count = 0; word_idx = 0; shift_in_word = 0; done_edge = 0;
        finished = 0; aborted = 0;
        for (int i = 0; i < n_words; i++) begin
            if (use_fixed) w = sel ? 8'hFF : fixedWord(i);
            else w = W'($urandom);
            words.push_back(w);
            for (int b = 0; b < W; b++)
                if (exp_bits.size() < cl) exp_bits.push_back(w[b]);
        end

        @(negedge clk);
        start = 1; data_valid = 0;
        for (int k = 1; k <= 400 && !finished && !aborted; k++) begin
            @(negedge clk);
            start = 0; abort = 0; data_valid = 0;
            if (done) begin
                finished = 1;
                done_edge = k - 1;
            end else begin
                if (!scan_en) checkOutput("scanOutIdle", scan_out, 0);
                else begin
                    got_bits.push_back(scan_out);
                    en_count++;
                    shift_in_word++;
                end
                if (do_abort && scan_en && word_idx == 2 && shift_in_word == 3) begin
                    abort = 1;
                    aborted = 1;
                end else if (data_ready) begin
                    if ($urandom_range(99) >= gap_pct && word_idx < words.size()) begin
                        data_valid = 1;
                        data_in = words[word_idx];
                        word_idx++;
                        shift_in_word = 0;
                    end else begin
                        gaps++;
                    end
                end else if ($urandom_range(99) < junk_pct) begin
                    data_valid = 1;
                    data_in = W'($urandom);
                end
                if (busy && !aborted && $urandom_range(99) < junk_pct) start = 1;
            end
        end

        if (aborted) begin
            @(negedge clk);
            abort = 0; data_valid = 0;
            checkOutput("abortScanEn", scan_en, 0);
            checkOutput("abortBusy", busy, 0);
            checkOutput("abortDone", done, 0);
            checkOutput("abortReady", data_ready, 0);
            return;
        end
        data_valid = 0;
        if (!finished) begin
            checkOutput("doneTimeout", 0, 1);
            return;
        end
        checkOutput("doneEdge", done_edge, n_words + cl + gaps);
        checkOutput("scanEnCount", en_count, cl);
        for (int i = 0; i < cl; i++)
            checkOutput($sformatf("bit%0d", i), (i < got_bits.size()) ? 32'(got_bits[i]) : 32'd2,
                        32'(exp_bits[i]));
        checkOutput("doneReady", data_ready, 0);
        checkOutput("doneBusy", busy, 0);
        @(negedge clk);
        checkOutput("doneHold", done, 1);
        checkOutput("doneHoldScanEn", scan_en, 0);
    endtask

    task automatic startWithAbort();
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        checkOutput("startAbortBusy", busy, 0);
        checkOutput("startAbortReady", data_ready, 0);
        @(negedge clk);
        checkOutput("startAbortStill", busy, 0);
    endtask

    task automatic resetMidShift();
        int k;
        k = 0;
        @(negedge clk);
        start = 1; data_valid = 1; data_in = 8'hFF;
        @(negedge clk);
        start = 0;
        while (!scan_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reachShift", scan_en, 1);
        #2 rst_n = 0;
        #1;
        checkOutput("rstScanEn", scan_en, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstScanOut", scan_out, 0);
        data_valid = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("idleAfterReset", busy, 0);
        end
    endtask

    initial begin
        rst_n = 1; start = 0; abort = 0; data_in = '0; data_valid = 0; sel = 0;
        #1 rst_n = 0;
        #2;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetScanEn", scan_en, 0);
        checkOutput("resetScanOut", scan_out, 0);
        checkOutput("resetReady", data_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        checkOutput("idleAfterRelease", busy, 0);

        applyStimulus(1, 0, 0, 0);
        sel = 1;
        applyStimulus(1, 0, 0, 0);
        sel = 0;
        applyStimulus(0, 40, 30, 0);
        applyStimulus(0, 40, 30, 0);
        sel = 1;
        applyStimulus(0, 30, 30, 0);
        applyStimulus(0, 30, 30, 0);
        sel = 0;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 20, 20, 0);
        startWithAbort();
        applyStimulus(0, 0, 20, 0);
        resetMidShift();
        applyStimulus(0, 20, 20, 0);
        sel = 1;
        applyStimulus(0, 20, 20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
